// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris session control: menu scan codes, session
// state encoding and a small population-count helper.
package tetris_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ENTER = 8'h5a;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_PAUSE = 8'h4d;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } session_state_e;

  // Boards are limited to four, so a fixed 4-bit argument covers every build.
  function automatic logic [2:0] alive_count(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// Free-running 0..CLK_HZ-1 cycle counter with synchronous clear; o_tick is
// high for the single cycle in which the counter wraps.
module sec_tick #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign o_tick = i_en && !i_clr && (cnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_session_ctrl.sv
// Session controller: mode menu, seconds countdown, pause/resume and
// multi-player elimination. The PAUSE state exists only with SESSION_PAUSE_EN.
module game_session_ctrl
  import tetris_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int CLK_HZ    = 25_000_000,
  parameter int COUNT_SEC = 3,
  localparam int MW       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_key,
  input  logic [N_PLAYERS-1:0] i_finish,
  output logic [2:0]           o_state,
  output logic [MW-1:0]        o_mode,
  output logic [2:0]           o_count,
  output logic                 o_start,
  output logic                 o_run,
  output logic [N_PLAYERS-1:0] o_active,
  output logic [N_PLAYERS-1:0] o_alive,
  output logic [N_PLAYERS-1:0] o_winner
);

  session_state_e       state_q, state_d;
  logic [7:0]           key_r, key_prev;
  logic                 key_evt;
  logic                 evt_up, evt_down, evt_enter, evt_esc;
`ifdef SESSION_PAUSE_EN
  logic                 evt_pause;
`endif
  logic [MW-1:0]        mode_q, mode_d;
  logic [2:0]           count_q, count_d;
  logic                 start_q, start_d;
  logic                 run_q, run_d;
  logic [N_PLAYERS-1:0] active_q, active_d;
  logic [N_PLAYERS-1:0] alive_q, alive_d;
  logic [N_PLAYERS-1:0] winner_q, winner_d;
  logic [N_PLAYERS-1:0] fin_hit, alive_left;
  logic [2:0]           left_cnt;
  logic                 tick;

  // The key is registered once, then compared with its own previous value,
  // so a held code yields exactly one event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_r    <= 8'h00;
      key_prev <= 8'h00;
    end else begin
      key_r    <= i_key;
      key_prev <= key_r;
    end
  end

  assign key_evt   = (key_r != 8'h00) && (key_r != key_prev);
  assign evt_up    = key_evt && (key_r == KEY_UP);
  assign evt_down  = key_evt && (key_r == KEY_DOWN);
  assign evt_enter = key_evt && (key_r == KEY_ENTER);
  assign evt_esc   = key_evt && (key_r == KEY_ESC);
`ifdef SESSION_PAUSE_EN
  assign evt_pause = key_evt && (key_r == KEY_PAUSE);
`endif

  sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_q != ST_COUNT),
    .i_en    (state_q == ST_COUNT),
    .o_tick  (tick)
  );

  assign fin_hit    = i_finish & alive_q;
  assign alive_left = alive_q & ~fin_hit;
  assign left_cnt   = alive_count(4'(alive_left));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    alive_d  = alive_q;
    winner_d = winner_q;
    start_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        alive_d  = '0;
        winner_d = '0;
        count_d  = 3'd0;
        if (evt_enter) begin
          state_d = ST_COUNT;
          count_d = 3'(COUNT_SEC);
          alive_d = active_q;
        end else if (evt_up) begin
          mode_d = (mode_q == '0) ? MW'(N_PLAYERS - 1) : mode_q - MW'(1);
        end else if (evt_down) begin
          mode_d = (mode_q == MW'(N_PLAYERS - 1)) ? '0 : mode_q + MW'(1);
        end
      end
      ST_COUNT: begin
        alive_d = active_q;
        if (evt_esc) begin
          state_d = ST_IDLE;
          count_d = 3'd0;
          alive_d = '0;
        end else if (tick) begin
          if (count_q == 3'd1) begin
            state_d = ST_PLAY;
            start_d = 1'b1;
            count_d = 3'd0;
          end else begin
            count_d = count_q - 3'd1;
          end
        end
      end
      ST_PLAY: begin
        if (evt_esc) begin
          state_d = ST_IDLE;
          alive_d = '0;
        end else if (fin_hit != '0) begin
          alive_d = alive_left;
          // A simultaneous last-board finish leaves alive_left empty: a draw.
          if (mode_q == '0 || left_cnt <= 3'd1) begin
            state_d  = ST_OVER;
            winner_d = (mode_q == '0) ? '0 : alive_left;
          end
        end
`ifdef SESSION_PAUSE_EN
        else if (evt_pause) begin
          state_d = ST_PAUSE;
        end
`endif
      end
      ST_PAUSE: begin
`ifdef SESSION_PAUSE_EN
        if (evt_esc) begin
          state_d = ST_IDLE;
          alive_d = '0;
        end else if (evt_pause) begin
          state_d = ST_PLAY;
        end
`else
        state_d = ST_IDLE;
        alive_d = '0;
`endif
      end
      ST_OVER: begin
        if (evt_enter || evt_esc) begin
          state_d  = ST_IDLE;
          alive_d  = '0;
          winner_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        alive_d  = '0;
        winner_d = '0;
        count_d  = 3'd0;
      end
    endcase
    run_d = (state_d == ST_PLAY);
    for (int i = 0; i < N_PLAYERS; i++) begin
      active_d[i] = (i <= int'(mode_d));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      count_q  <= 3'd0;
      start_q  <= 1'b0;
      run_q    <= 1'b0;
      active_q <= N_PLAYERS'(1);
      alive_q  <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      start_q  <= start_d;
      run_q    <= run_d;
      active_q <= active_d;
      alive_q  <= alive_d;
      winner_q <= winner_d;
    end
  end

  assign o_state  = state_q;
  assign o_mode   = mode_q;
  assign o_count  = count_q;
  assign o_start  = start_q;
  assign o_run    = run_q;
  assign o_active = active_q;
  assign o_alive  = alive_q;
  assign o_winner = winner_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl (3 players, 10-cycle seconds, 3 s
// countdown); pause expectations follow SESSION_PAUSE_EN.
module tb_game_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key = 8'h00;
  logic [2:0] finish = 3'b000;
  logic [2:0] state;
  logic [1:0] mode;
  logic [2:0] count;
  logic       start;
  logic       run;
  logic [2:0] active;
  logic [2:0] alive;
  logic [2:0] winner;

  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  game_session_ctrl #(
    .N_PLAYERS (3),
    .CLK_HZ    (10),
    .COUNT_SEC (3)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_key    (key),
    .i_finish (finish),
    .o_state  (state),
    .o_mode   (mode),
    .o_count  (count),
    .o_start  (start),
    .o_run    (run),
    .o_active (active),
    .o_alive  (alive),
    .o_winner (winner)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // Outputs reflect a key two edges after it is applied; released afterwards.
  task automatic press(input logic [7:0] code);
    key = code;
    step(2);
    key = 8'h00;
  endtask

  initial begin
    // reset
    step(2);
    exp(0); exp(0); exp(0); exp(0); exp(0); exp(1); exp(0); exp(0);
    chk("rst_state", 16'(state));
    chk("rst_mode", 16'(mode));
    chk("rst_count", 16'(count));
    chk("rst_start", 16'(start));
    chk("rst_run", 16'(run));
    chk("rst_active", 16'(active));
    chk("rst_alive", 16'(alive));
    chk("rst_winner", 16'(winner));
    rst_n = 1'b1;
    step(2);

    // menu wrap
    exp(1); press(8'h72); chk("down1", 16'(mode)); step(2);
    exp(2); press(8'h72); chk("down2", 16'(mode)); step(2);
    exp(0); press(8'h72); chk("down3_wrap", 16'(mode)); step(2);
    exp(2); press(8'h75); chk("up_wrap", 16'(mode)); step(2);
    exp(1); press(8'h75); chk("up", 16'(mode)); step(2);

    // held key gives one event
    key = 8'h72;
    step(2);
    exp(2); chk("hold_a", 16'(mode));
    step(1);
    exp(2); chk("hold_b", 16'(mode));
    step(98);
    exp(2); exp(7); chk("hold_c", 16'(mode)); chk("hold_active", 16'(active));
    key = 8'h00;
    step(2);

    // countdown
    exp(1); exp(3);
    press(8'h5a);
    chk("cnt_state", 16'(state));
    chk("cnt_3a", 16'(count));
    step(9);
    exp(3); chk("cnt_3b", 16'(count));
    step(1);
    exp(2); chk("cnt_2", 16'(count));
    step(10);
    exp(1); chk("cnt_1", 16'(count));
    step(9);
    exp(1); exp(0); exp(0);
    chk("cnt_29_state", 16'(state)); chk("cnt_29_start", 16'(start)); chk("cnt_29_run", 16'(run));
    step(1);
    exp(2); exp(1); exp(1); exp(0); exp(7);
    chk("play_state", 16'(state)); chk("play_start", 16'(start)); chk("play_run", 16'(run));
    chk("play_count", 16'(count)); chk("play_alive", 16'(alive));
    step(1);
    exp(0); exp(1);
    chk("play_start_low", 16'(start)); chk("play_run_hold", 16'(run));

    // elimination with a winner
    exp(5); exp(2);
    finish = 3'b010;
    step(1);
    chk("elim1_alive", 16'(alive)); chk("elim1_state", 16'(state));
    exp(4); exp(4); exp(0);
    finish = 3'b001;
    step(1);
    chk("win_state", 16'(state)); chk("win_winner", 16'(winner)); chk("win_run", 16'(run));
    finish = 3'b000;
    step(3);
    exp(4); chk("win_held", 16'(winner));
    exp(0); exp(0); exp(0);
    press(8'h5a);
    chk("over_enter_state", 16'(state)); chk("idle_winner", 16'(winner)); chk("idle_alive", 16'(alive));
    step(2);

    // elimination ending in a draw
    press(8'h5a);
    step(30);
    exp(2); chk("play2_state", 16'(state));
    exp(5);
    finish = 3'b010;
    step(1);
    chk("elim2_alive", 16'(alive));
    exp(4); exp(0);
    finish = 3'b101;
    step(1);
    chk("draw_state", 16'(state)); chk("draw_winner", 16'(winner));
    finish = 3'b000;
    exp(0);
    press(8'h76);
    chk("over_esc_state", 16'(state));
    step(2);

    // single player
    exp(0); exp(1);
    press(8'h72);
    chk("mode_1p", 16'(mode)); chk("active_1p", 16'(active));
    step(2);
    press(8'h5a);
    step(30);
    exp(2); exp(1); chk("p1_state", 16'(state)); chk("p1_alive", 16'(alive));
    exp(4); exp(0); exp(0);
    finish = 3'b001;
    step(1);
    chk("p1_over", 16'(state)); chk("p1_winner", 16'(winner)); chk("p1_run", 16'(run));
    finish = 3'b000;
    exp(0);
    press(8'h5a);
    chk("p1_idle", 16'(state));
    step(2);

    // pause
    press(8'h5a);
    step(30);
    exp(2); chk("pz_play", 16'(state));
`ifdef SESSION_PAUSE_EN
    exp(3); exp(0);
    press(8'h4d);
    chk("pz_state", 16'(state)); chk("pz_run", 16'(run));
    exp(3); exp(1);
    finish = 3'b001;
    step(1);
    chk("pz_fin_state", 16'(state)); chk("pz_fin_alive", 16'(alive));
    finish = 3'b000;
    exp(2); exp(1); exp(0);
    press(8'h4d);
    chk("resume_state", 16'(state)); chk("resume_run", 16'(run)); chk("resume_start", 16'(start));
`else
    exp(2); exp(1);
    press(8'h4d);
    chk("nopz_state", 16'(state)); chk("nopz_run", 16'(run));
`endif
    step(2);
    exp(0); exp(0); exp(0);
    press(8'h76);
    chk("esc_play_state", 16'(state)); chk("esc_play_run", 16'(run)); chk("esc_play_alive", 16'(alive));
    step(2);

    // esc during countdown
    press(8'h5a);
    step(5);
    exp(0); exp(0); exp(0); exp(0);
    press(8'h76);
    chk("esc_cnt_state", 16'(state)); chk("esc_cnt_count", 16'(count));
    chk("esc_cnt_run", 16'(run)); chk("esc_cnt_alive", 16'(alive));
    step(2);

    // async reset mid-countdown
    press(8'h5a);
    step(5);
    exp(3); chk("pre_rst_count", 16'(count));
    rst_n = 1'b0;
    #1;
    exp(0); exp(0); exp(0); exp(0);
    chk("arst_state", 16'(state)); chk("arst_count", 16'(count));
    chk("arst_start", 16'(start)); chk("arst_mode", 16'(mode));
    step(2);
    rst_n = 1'b1;
    step(40);
    exp(0); exp(0); chk("post_rst_state", 16'(state)); chk("post_rst_start", 16'(start));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
